// File: rtl/alu_ctrl_exec.sv
// ALU control decoder plus execute unit for the multi-cycle core.
// Decodes ALUOp/funct3/funct7/opcode into a 4-bit control code, executes
// single-cycle ops in one cycle and MUL as an XLEN-step shift-add, and
// holds the result behind a valid/ready handshake.
module alu_ctrl_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_ctrl_q,
  output logic            illegal_op,
  output logic            busy
);

  localparam logic [3:0] C_ADD   = 4'b0000;
  localparam logic [3:0] C_SUB   = 4'b0001;
  localparam logic [3:0] C_AND   = 4'b0010;
  localparam logic [3:0] C_OR    = 4'b0011;
  localparam logic [3:0] C_XOR   = 4'b0100;
  localparam logic [3:0] C_SLL   = 4'b0101;
  localparam logic [3:0] C_SRL   = 4'b0110;
  localparam logic [3:0] C_SRA   = 4'b0111;
  localparam logic [3:0] C_SLT   = 4'b1000;
  localparam logic [3:0] C_SLTU  = 4'b1001;
  localparam logic [3:0] C_MUL   = 4'b1010;
  localparam logic [3:0] C_PASSB = 4'b1011;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]      state_reg;
  logic [XLEN-1:0] result_reg;
  logic [3:0]      ctrl_reg;
  logic            illegal_reg;
  logic [XLEN-1:0] acc_reg;
  logic [XLEN-1:0] mcand_reg;
  logic [XLEN-1:0] mplier_reg;
  logic [SHW-1:0]  count_reg;

  logic [3:0]      dec_ctrl;
  logic            dec_illegal;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] acc_next;
  logic [SHW-1:0]  sh;
  logic            accept;

  // funct3 map shared by R-type and I-type; 000 and 101 are resolved by the caller
  function automatic logic [3:0] f3_map(input logic [2:0] f3);
    case (f3)
      3'b001:  f3_map = C_SLL;
      3'b010:  f3_map = C_SLT;
      3'b011:  f3_map = C_SLTU;
      3'b100:  f3_map = C_XOR;
      3'b110:  f3_map = C_OR;
      3'b111:  f3_map = C_AND;
      default: f3_map = C_ADD;
    endcase
  endfunction

  // Control decode; unsupported encodings fall back to ADD and flag illegal
  always_comb begin
    dec_ctrl    = C_ADD;
    dec_illegal = 1'b0;
    case (alu_op)
      3'b000: dec_ctrl = C_ADD;
      3'b001: dec_ctrl = C_SUB;
      3'b010: begin
        if (opcode != OPC_RTYPE) begin
          dec_illegal = 1'b1;
        end else if (funct7 == 7'h01) begin
          if (funct3 == 3'b000) dec_ctrl = C_MUL;
          else                  dec_illegal = 1'b1;
        end else if (funct7 != 7'h00 && funct7 != 7'h20) begin
          dec_illegal = 1'b1;
        end else if (funct3 == 3'b000) begin
          dec_ctrl = (funct7 == 7'h20) ? C_SUB : C_ADD;
        end else if (funct3 == 3'b101) begin
          dec_ctrl = (funct7 == 7'h20) ? C_SRA : C_SRL;
        end else begin
          dec_ctrl = f3_map(funct3);
        end
      end
      3'b011: begin
        if (funct3 == 3'b000)      dec_ctrl = C_ADD;
        else if (funct3 == 3'b101) dec_ctrl = (funct7 == 7'h20) ? C_SRA : C_SRL;
        else                       dec_ctrl = f3_map(funct3);
      end
      3'b100:  dec_ctrl = C_PASSB;
      default: dec_illegal = 1'b1;
    endcase
  end

  assign sh = op_b[SHW-1:0];

  // Single-cycle datapath evaluated on the acceptance cycle's inputs
  always_comb begin
    alu_out = '0;
    case (dec_ctrl)
      C_ADD:   alu_out = op_a + op_b;
      C_SUB:   alu_out = op_a - op_b;
      C_AND:   alu_out = op_a & op_b;
      C_OR:    alu_out = op_a | op_b;
      C_XOR:   alu_out = op_a ^ op_b;
      C_SLL:   alu_out = op_a << sh;
      C_SRL:   alu_out = op_a >> sh;
      C_SRA:   alu_out = $signed(op_a) >>> sh;
      C_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      C_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      C_PASSB: alu_out = op_b;
      default: alu_out = '0;
    endcase
  end

  // One shift-add step; the final step's sum is written straight to result
  always_comb begin
    acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  end

  assign in_ready   = (state_reg == S_IDLE) || ((state_reg == S_HOLD) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_reg == S_HOLD);
  assign busy       = (state_reg == S_MUL);
  assign result     = result_reg;
  assign alu_ctrl_q = ctrl_reg;
  assign illegal_op = illegal_reg;

  // Handshake FSM, operand capture and iterative multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      result_reg  <= '0;
      ctrl_reg    <= C_ADD;
      illegal_reg <= 1'b0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      count_reg   <= '0;
    end else begin
      case (state_reg)
        S_MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + SHW'(1);
          if (count_reg == SHW'(XLEN-1)) begin
            result_reg <= acc_next;
            state_reg  <= S_HOLD;
          end
        end
        default: begin
          if (accept) begin
            ctrl_reg    <= dec_ctrl;
            illegal_reg <= dec_illegal;
            if (dec_ctrl == C_MUL) begin
              mcand_reg  <= op_a;
              mplier_reg <= op_b;
              acc_reg    <= '0;
              count_reg  <= '0;
              state_reg  <= S_MUL;
            end else begin
              result_reg <= alu_out;
              state_reg  <= S_HOLD;
            end
          end else if (state_reg == S_HOLD && out_ready) begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed bench for alu_ctrl_exec: decode, datapath, MUL latency,
// hold/backpressure, back-to-back issue, reset abort and illegal encodings.
module tb_alu_ctrl_exec;

  localparam int XLEN = 32;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      alu_op = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic [6:0]      opcode = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic [3:0]      alu_ctrl_q;
  logic            illegal_op;
  logic            busy;

  int cmp_cnt = 0;
  int fail_cnt = 0;

  alu_ctrl_exec #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .alu_ctrl_q(alu_ctrl_q), .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] a_op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [6:0] opc, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    alu_op = a_op; funct3 = f3; funct7 = f7; opcode = opc; op_a = a; op_b = b;
  endtask

  // Present one op for a single acceptance edge; returns in cycle 1
  task automatic issue(input logic [2:0] a_op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [6:0] opc, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    set_op(a_op, f3, f7, opc, a, b);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    set_op(3'b000, 3'b000, 7'h00, 7'h00, '1, '1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Waits until busy drops; returns the cycle index (cycle 1 = after acceptance)
  task automatic wait_mul(output int n);
    n = 1;
    while (busy && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    cmp_cnt++;
    if (out_valid !== 1'b0 || result !== '0 || alu_ctrl_q !== 4'b0000 ||
        illegal_op !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset: ov=%b res=%h ctrl=%b ill=%b busy=%b rdy=%b, required 0 0 0000 0 0 1",
               out_valid, result, alu_ctrl_q, illegal_op, busy, in_ready);
    end
    $display("reset: ov=%b res=%h ctrl=%b", out_valid, result, alu_ctrl_q);
  endtask

  task automatic test_add_sub();
    issue(3'b010, 3'b000, 7'h00, RT, 32'd5, 32'd3);
    cmp_cnt++;
    if (out_valid !== 1'b1 || result !== 32'd8 || alu_ctrl_q !== 4'b0000 || illegal_op !== 1'b0) begin
      fail_cnt++;
      $display("FAIL add: ov=%b res=%h ctrl=%b ill=%b, required 1 00000008 0000 0", out_valid, result, alu_ctrl_q, illegal_op);
    end
    $display("add 5+3: res=%h ctrl=%b", result, alu_ctrl_q);
    drain();
    cmp_cnt++;
    if (out_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL drain_idle: ov=%b, required 0", out_valid);
    end
    issue(3'b010, 3'b000, 7'h20, RT, 32'd5, 32'd3);
    cmp_cnt++;
    if (out_valid !== 1'b1 || result !== 32'd2 || alu_ctrl_q !== 4'b0001) begin
      fail_cnt++;
      $display("FAIL sub: ov=%b res=%h ctrl=%b, required 1 00000002 0001", out_valid, result, alu_ctrl_q);
    end
    $display("sub 5-3: res=%h ctrl=%b", result, alu_ctrl_q);
    drain();
  endtask

  task automatic test_shift();
    issue(3'b011, 3'b101, 7'h20, IT, 32'h80000000, 32'd4);
    cmp_cnt++;
    if (result !== 32'hF8000000 || alu_ctrl_q !== 4'b0111) begin
      fail_cnt++;
      $display("FAIL srai: res=%h ctrl=%b, required f8000000 0111", result, alu_ctrl_q);
    end
    $display("srai: res=%h ctrl=%b", result, alu_ctrl_q);
    drain();
    issue(3'b011, 3'b101, 7'h00, IT, 32'h80000000, 32'd4);
    cmp_cnt++;
    if (result !== 32'h08000000 || alu_ctrl_q !== 4'b0110) begin
      fail_cnt++;
      $display("FAIL srli: res=%h ctrl=%b, required 08000000 0110", result, alu_ctrl_q);
    end
    $display("srli: res=%h ctrl=%b", result, alu_ctrl_q);
    drain();
    // Shift amount uses only the low 5 bits: 0x21 shifts by 1
    issue(3'b010, 3'b001, 7'h00, RT, 32'h00000003, 32'h00000021);
    cmp_cnt++;
    if (result !== 32'h00000006 || alu_ctrl_q !== 4'b0101) begin
      fail_cnt++;
      $display("FAIL sll_mask: res=%h ctrl=%b, required 00000006 0101", result, alu_ctrl_q);
    end
    $display("sll mask: res=%h ctrl=%b", result, alu_ctrl_q);
    drain();
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    set_op(3'b010, 3'b010, 7'h00, RT, 32'hFFFFFFFF, 32'd1);
    in_valid = 1'b1;
    step();
    cmp_cnt++;
    if (out_valid !== 1'b1 || result !== 32'd1 || alu_ctrl_q !== 4'b1000 || in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL b2b_slt: ov=%b res=%h ctrl=%b rdy=%b, required 1 00000001 1000 1", out_valid, result, alu_ctrl_q, in_ready);
    end
    $display("b2b slt: res=%h ctrl=%b", result, alu_ctrl_q);
    set_op(3'b010, 3'b011, 7'h00, RT, 32'hFFFFFFFF, 32'd1);
    step();
    cmp_cnt++;
    if (out_valid !== 1'b1 || result !== 32'd0 || alu_ctrl_q !== 4'b1001 || in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL b2b_sltu: ov=%b res=%h ctrl=%b rdy=%b, required 1 00000000 1001 1", out_valid, result, alu_ctrl_q, in_ready);
    end
    $display("b2b sltu: res=%h ctrl=%b", result, alu_ctrl_q);
    // MUL accepted straight from HOLD
    set_op(3'b010, 3'b000, 7'h01, RT, 32'd3, 32'd4);
    step();
    in_valid = 1'b0;
    cmp_cnt++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_mul_start: busy=%b ov=%b, required 1 0", busy, out_valid);
    end
    wait_mul(n);
    cmp_cnt++;
    if (n !== 33 || out_valid !== 1'b1 || result !== 32'd12) begin
      fail_cnt++;
      $display("FAIL b2b_mul: cycle=%0d ov=%b res=%h, required 33 1 0000000c", n, out_valid, result);
    end
    $display("b2b mul 3*4: cycle=%0d res=%h", n, result);
    step();
    out_ready = 1'b0;
    cmp_cnt++;
    if (out_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_idle: ov=%b, required 0", out_valid);
    end
  endtask

  task automatic test_mul();
    int n;
    issue(3'b010, 3'b000, 7'h01, RT, 32'd7, 32'd6);
    cmp_cnt++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || alu_ctrl_q !== 4'b1010) begin
      fail_cnt++;
      $display("FAIL mul_start: busy=%b rdy=%b ov=%b ctrl=%b, required 1 0 0 1010", busy, in_ready, out_valid, alu_ctrl_q);
    end
    wait_mul(n);
    cmp_cnt++;
    if (n !== 33 || out_valid !== 1'b1 || result !== 32'd42 || alu_ctrl_q !== 4'b1010) begin
      fail_cnt++;
      $display("FAIL mul_7x6: cycle=%0d ov=%b res=%h ctrl=%b, required 33 1 0000002a 1010", n, out_valid, result, alu_ctrl_q);
    end
    $display("mul 7*6: cycle=%0d res=%h", n, result);
    // Backpressure with a competing request that must be ignored
    set_op(3'b000, 3'b000, 7'h00, RT, 32'd100, 32'd100);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp_cnt++;
      if (out_valid !== 1'b1 || result !== 32'd42 || in_ready !== 1'b0 || alu_ctrl_q !== 4'b1010) begin
        fail_cnt++;
        $display("FAIL mul_hold[%0d]: ov=%b res=%h rdy=%b ctrl=%b, required 1 0000002a 0 1010", i, out_valid, result, in_ready, alu_ctrl_q);
      end
    end
    in_valid = 1'b0;
    drain();
    issue(3'b010, 3'b000, 7'h01, RT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_mul(n);
    cmp_cnt++;
    if (n !== 33 || out_valid !== 1'b1 || result !== 32'd1) begin
      fail_cnt++;
      $display("FAIL mul_ffxff: cycle=%0d ov=%b res=%h, required 33 1 00000001", n, out_valid, result);
    end
    $display("mul ff*ff: cycle=%0d res=%h", n, result);
    drain();
  endtask

  task automatic test_mul_reset();
    int seen;
    issue(3'b010, 3'b000, 7'h01, RT, 32'd9, 32'd9);
    for (int i = 1; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1 || alu_ctrl_q !== 4'b0000) begin
      fail_cnt++;
      $display("FAIL mul_abort: busy=%b ov=%b res=%h rdy=%b ctrl=%b, required 0 0 0 1 0000", busy, out_valid, result, in_ready, alu_ctrl_q);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    cmp_cnt++;
    if (seen !== 0) begin
      fail_cnt++;
      $display("FAIL mul_discard: out_valid cycles=%0d, required 0", seen);
    end
    issue(3'b000, 3'b000, 7'h00, 7'h00, 32'd1, 32'd1);
    cmp_cnt++;
    if (out_valid !== 1'b1 || result !== 32'd2) begin
      fail_cnt++;
      $display("FAIL post_reset_add: ov=%b res=%h, required 1 00000002", out_valid, result);
    end
    $display("mul abort then add: res=%h", result);
    drain();
  endtask

  task automatic test_illegal();
    issue(3'b010, 3'b100, 7'h01, RT, 32'd10, 32'd20);
    cmp_cnt++;
    if (result !== 32'd30 || illegal_op !== 1'b1 || alu_ctrl_q !== 4'b0000) begin
      fail_cnt++;
      $display("FAIL ill_m_f3: res=%h ill=%b ctrl=%b, required 0000001e 1 0000", result, illegal_op, alu_ctrl_q);
    end
    $display("illegal m/f3: res=%h ill=%b", result, illegal_op);
    drain();
    issue(3'b010, 3'b110, 7'h10, RT, 32'd1, 32'd2);
    cmp_cnt++;
    if (result !== 32'd3 || illegal_op !== 1'b1 || alu_ctrl_q !== 4'b0000) begin
      fail_cnt++;
      $display("FAIL ill_f7: res=%h ill=%b ctrl=%b, required 00000003 1 0000", result, illegal_op, alu_ctrl_q);
    end
    drain();
    issue(3'b110, 3'b000, 7'h00, RT, 32'd4, 32'd5);
    cmp_cnt++;
    if (result !== 32'd9 || illegal_op !== 1'b1 || alu_ctrl_q !== 4'b0000) begin
      fail_cnt++;
      $display("FAIL ill_aluop: res=%h ill=%b ctrl=%b, required 00000009 1 0000", result, illegal_op, alu_ctrl_q);
    end
    $display("illegal aluop: res=%h ill=%b", result, illegal_op);
    drain();
    issue(3'b100, 3'b000, 7'h00, 7'b0110111, 32'hDEADBEEF, 32'h12345000);
    cmp_cnt++;
    if (result !== 32'h12345000 || illegal_op !== 1'b0 || alu_ctrl_q !== 4'b1011) begin
      fail_cnt++;
      $display("FAIL passb: res=%h ill=%b ctrl=%b, required 12345000 0 1011", result, illegal_op, alu_ctrl_q);
    end
    $display("passb: res=%h ill=%b", result, illegal_op);
    drain();
    // I-type funct3 000 ignores funct7=0x20 (ADDI, not SUB)
    issue(3'b011, 3'b000, 7'h20, IT, 32'd5, 32'd3);
    cmp_cnt++;
    if (result !== 32'd8 || alu_ctrl_q !== 4'b0000 || illegal_op !== 1'b0) begin
      fail_cnt++;
      $display("FAIL addi_f7: res=%h ctrl=%b ill=%b, required 00000008 0000 0", result, alu_ctrl_q, illegal_op);
    end
    drain();
    // R-type AND and OR
    issue(3'b010, 3'b111, 7'h00, RT, 32'hF0F0F0F0, 32'hFF00FF00);
    cmp_cnt++;
    if (result !== 32'hF000F000 || alu_ctrl_q !== 4'b0010) begin
      fail_cnt++;
      $display("FAIL and: res=%h ctrl=%b, required f000f000 0010", result, alu_ctrl_q);
    end
    drain();
    issue(3'b010, 3'b110, 7'h00, RT, 32'hF0F0F0F0, 32'h0F000000);
    cmp_cnt++;
    if (result !== 32'hFFF0F0F0 || alu_ctrl_q !== 4'b0011) begin
      fail_cnt++;
      $display("FAIL or: res=%h ctrl=%b, required fff0f0f0 0011", result, alu_ctrl_q);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shift();
    test_back_to_back();
    test_mul();
    test_mul_reset();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_exec.md
Name: alu_ctrl_exec

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes ALUOp/funct3/funct7/opcode into a 4-bit ALU control code and executes the operation on registered operands. Single-cycle ops produce a registered result one cycle after acceptance. MUL (RV32M low word) runs as an iterative shift-add. The block sits in the execute stage with valid/ready handshakes on both sides, for the multi-cycle core variant.

Parameters:
XLEN, 32, operand/result width (power of two, >=8)
SHW, $clog2(XLEN), shift-amount width taken from op_b[SHW-1:0]

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
in_valid  in  1  operation request
in_ready  out  1  block can accept this cycle
alu_op  in  3  main-decoder ALUOp
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
opcode  in  7  instruction opcode
op_a  in  XLEN  operand A
op_b  in  XLEN  operand B / immediate
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  registered result
alu_ctrl_q  out  4  control code of the op in flight/held
illegal_op  out  1  held op had an unsupported encoding
busy  out  1  high in MUL state

Behaviour:
- Control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, MUL 1010, PASSB 1011.
- ALUOp decode:
  - 000 -> ADD.
  - 001 -> SUB.
  - 010 (R-type, opcode 0110011) -> funct3 000: SUB if funct7=0x20, MUL if funct7=0x01, else ADD. 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101: SRA if funct7=0x20, else SRL; 110 OR; 111 AND.
  - 011 (I-type ALU) -> same map by funct3, except: funct3 000 is always ADD; funct7=0x20 is honoured only for funct3 101 (SRAI).
  - 100 -> PASSB.
  - 101-111 -> ADD with illegal_op=1.
- Any funct7=0x01 R-type with funct3!=000 -> ADD with illegal_op=1. Any other funct7 outside {0x00,0x20,0x01} on an R-type -> ADD with illegal_op=1.
- Arithmetic: XLEN-bit, wrap-around, no carry/overflow outputs.
  - SLT is a signed compare; SLTU is unsigned; both give a zero-extended 0/1.
  - SRA sign-fills.
  - Shifts use op_b[SHW-1:0] only.
  - MUL result = low XLEN bits of op_a*op_b.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: in_ready=1. On in_valid, latch operands and decode. Non-MUL -> compute, register result, go to HOLD. MUL -> go to MUL with acc=0 and count=0.
  - MUL: busy=1, in_ready=0. Each cycle: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; count++. After XLEN iterations, result=acc and go to HOLD.
  - HOLD: out_valid=1. result, alu_ctrl_q and illegal_op stay stable until out_ready. in_ready = out_ready.
  - HOLD with out_ready and in_valid in the same cycle: the new op is accepted (back-to-back). Non-MUL -> stay in HOLD with the new result; MUL -> go to MUL.
  - HOLD with out_ready and no in_valid -> IDLE.
- Latency (acceptance edge = cycle 0): non-MUL out_valid in cycle 1; MUL out_valid in cycle XLEN+1.
- Throughput: 1 op/cycle for non-MUL with out_ready held high.
- Inputs are sampled only on the acceptance edge. Later changes to the inputs have no effect.
- Reset (any state, including mid-MUL): state=IDLE, out_valid=0, result=0, alu_ctrl_q=0000, illegal_op=0, busy=0, count=0, acc=0. An in-flight MUL is discarded and no out_valid is produced for it.

Test Plan:
- alu_op=010, funct3=000, funct7=0x00, op_a=5, op_b=3 -> cycle 1: out_valid=1, result=8, alu_ctrl_q=0000. Repeat with funct7=0x20 -> result=2, ctrl 0001.
- alu_op=011, funct3=101, funct7=0x20, op_a=0x80000000, op_b=4 -> result 0xF8000000 (SRA). With funct7=0x00 -> 0x08000000 (SRL).
- op_a=0xFFFFFFFF, op_b=1: SLT -> 1, SLTU -> 0. Issue back-to-back with out_ready=1 -> results appear on consecutive cycles, in_ready stays 1.
- R-type MUL with op_a=7, op_b=6 -> busy=1 for 32 cycles, out_valid at cycle 33 with result=42, ctrl 1010. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0. op_a=op_b=0xFFFFFFFF -> result 1.
- Start MUL, assert rst at cycle 10 -> next cycle state IDLE, busy=0, out_valid=0, result=0. A following ADD 1+1 -> 2 in 1 cycle.
- funct7=0x01, funct3=100 (R-type) -> result=op_a+op_b, illegal_op=1. alu_op=110 -> ADD with illegal_op=1. alu_op=100, op_b=0x12345000 -> result 0x12345000, illegal_op=0.
